outport_arbiter: RTL and testbench

Shares one external output bus among NUM_CH cell output ports. Each port's `out_data`/`out_data_en` stream feeds a per-channel 2-entry FIFO, and a round-robin scheduler drains the FIFOs onto a single valid/ready bus tagged with the channel id. The block sits between the cell array's saturating outports and the host-facing interface. Overruns are counted as sticky per-channel drop flags rather than stalling the cells, because the outports have no backpressure.

---
 rtl/outport_arbiter_if.sv | 29 ++
 rtl/outport_arbiter.sv | 93 +++++++++
 tb/tb_outport_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/outport_arbiter_if.sv
// outport_arbiter_if: groups the channel inputs, shared output bus and drop-flag signals of outport_arbiter
//   ch_data/ch_data_en : packed channel words and per-channel write strobes
//   bus_data/bus_id/bus_valid/bus_ready : shared valid/ready output bus tagged with channel id
//   drop_flags/drop_clr : sticky per-channel overrun flags and their clears
//   busy : output register or any FIFO holds a word
//   slave = arbiter side, master = environment side
interface outport_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2,
    parameter int MSB    = 31
);
    logic [NUM_CH*(MSB+1)-1:0] ch_data;
    logic [NUM_CH-1:0]         ch_data_en;
    logic [MSB:0]              bus_data;
    logic [ID_W-1:0]           bus_id;
    logic                      bus_valid;
    logic                      bus_ready;
    logic [NUM_CH-1:0]         drop_flags;
    logic [NUM_CH-1:0]         drop_clr;
    logic                      busy;
    modport slave (
        input  ch_data, ch_data_en, bus_ready, drop_clr,
        output bus_data, bus_id, bus_valid, drop_flags, busy
    );
    modport master (
        output ch_data, ch_data_en, bus_ready, drop_clr,
        input  bus_data, bus_id, bus_valid, drop_flags, busy
    );
endinterface

// File: rtl/outport_arbiter.sv
// outport_arbiter: round-robin merge of NUM_CH outport streams through 2-entry FIFOs onto one valid/ready bus
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : outport_arbiter_if.slave (channel inputs, output bus, drop flags, busy)
module outport_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2,
    parameter int MSB    = 31
) (
    input  logic              clk,
    input  logic              rst,
    outport_arbiter_if.slave  bus
);
    typedef enum logic {EMPTY, HOLD} state_t;
    state_t            r_state, w_state_nxt;
    logic [MSB:0]      r_mem [NUM_CH][2];
    logic [1:0]        r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_rp, r_wp, r_drop;
    logic [NUM_CH-1:0] w_pop, w_push, w_drop, w_nonempty;
    logic [ID_W-1:0]   r_last, r_id, w_sel, w_idx;
    logic [MSB:0]      r_data;
    logic              w_load, w_found;

    // EMPTY always takes a word; HOLD only when the current one is accepted
    assign w_load = (r_state == EMPTY) || bus.bus_ready;

    // Scan from last_grant+NUM_CH down to last_grant+1 so the lowest offset wins
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_idx = r_last + ID_W'(i);
            if (r_cnt[w_idx] != 2'd0) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_pop[k]      = w_load && w_found && (w_sel == ID_W'(k));
        // A full FIFO still accepts a push when its head leaves in the same cycle
        assign w_push[k]     = bus.ch_data_en[k] && ((r_cnt[k] != 2'd2) || w_pop[k]);
        assign w_drop[k]     = bus.ch_data_en[k] && !w_push[k];
        assign w_nonempty[k] = r_cnt[k] != 2'd0;
    end

    always_comb begin
        w_state_nxt = w_load ? (w_found ? HOLD : EMPTY) : r_state;
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= EMPTY;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last <= ID_W'(NUM_CH - 1);
            r_data <= '0;
            r_id   <= '0;
            r_drop <= '0;
            r_rp   <= '0;
            r_wp   <= '0;
            for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= '0;
        end else begin
            if (w_load && w_found) begin
                r_data <= r_mem[w_sel][r_rp[w_sel]];
                r_id   <= w_sel;
                r_last <= w_sel;
            end
            // Set dominates clear on the same channel
            r_drop <= (r_drop & ~bus.drop_clr) | w_drop;
            for (int k = 0; k < NUM_CH; k++) begin
                r_cnt[k] <= r_cnt[k] + {1'b0, w_push[k]} - {1'b0, w_pop[k]};
                r_rp[k]  <= r_rp[k] ^ w_pop[k];
                r_wp[k]  <= r_wp[k] ^ w_push[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++)
            if (w_push[k]) r_mem[k][r_wp[k]] <= bus.ch_data[k*(MSB+1) +: MSB+1];
    end

    assign bus.bus_data   = r_data;
    assign bus.bus_id     = r_id;
    assign bus.bus_valid  = (r_state == HOLD);
    assign bus.drop_flags = r_drop;
    assign bus.busy       = (r_state == HOLD) || (|w_nonempty);
endmodule

// File: tb/tb_outport_arbiter.sv
// tb_outport_arbiter: directed and randomized checks of outport_arbiter against a queue-based reference model
module tb_outport_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    outport_arbiter_if #(.NUM_CH(N), .ID_W(2), .MSB(31)) bif ();
    outport_arbiter #(.NUM_CH(N), .ID_W(2), .MSB(31)) dut (.clk(clk), .rst(rst), .bus(bif.slave));

    always #5 clk = ~clk;

    logic [31:0] q [N][$];
    logic        m_valid;
    logic [31:0] m_data;
    int          m_id;
    int          m_last;
    logic [N-1:0] m_drop;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Next-cycle behaviour: pop the round-robin winner first, then append pushes behind it
    task automatic model_step();
        logic [N-1:0] dr;
        int sel;
        dr  = '0;
        sel = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) q[k].delete();
            m_valid = 1'b0; m_data = '0; m_id = 0; m_last = N - 1; m_drop = '0;
            return;
        end
        if (!m_valid || bif.bus_ready) begin
            for (int i = 1; i <= N; i++)
                if (sel < 0 && q[(m_last + i) % N].size() > 0) sel = (m_last + i) % N;
            if (sel >= 0) begin
                m_data  = q[sel].pop_front();
                m_id    = sel;
                m_last  = sel;
                m_valid = 1'b1;
            end else m_valid = 1'b0;
        end
        for (int k = 0; k < N; k++)
            if (bif.ch_data_en[k]) begin
                if (q[k].size() < 2) q[k].push_back(bif.ch_data[k*32 +: 32]);
                else dr[k] = 1'b1;
            end
        m_drop = (m_drop & ~bif.drop_clr) | dr;
    endtask

    task automatic tick();
        logic busy_exp;
        model_step();
        @(posedge clk);
        #1;
        busy_exp = m_valid;
        for (int k = 0; k < N; k++) if (q[k].size() > 0) busy_exp = 1'b1;
        chk("m_valid", bif.bus_valid, m_valid);
        if (m_valid) begin
            chk("m_data", bif.bus_data, m_data);
            chk("m_id", bif.bus_id, m_id);
        end
        chk("m_drop", bif.drop_flags, m_drop);
        chk("m_busy", bif.busy, busy_exp);
    endtask

    task automatic idle();
        bif.ch_data_en = '0;
        bif.drop_clr   = '0;
    endtask

    task automatic put(int ch, logic [31:0] d);
        bif.ch_data[ch*32 +: 32] = d;
        bif.ch_data_en[ch]       = 1'b1;
    endtask

    task automatic expect_word(string tag, int id, logic [31:0] d);
        tick();
        chk({tag, "_valid"}, bif.bus_valid, 1);
        chk({tag, "_id"}, bif.bus_id, id);
        chk({tag, "_data"}, bif.bus_data, d);
    endtask

    task automatic expect_idle(string tag);
        tick();
        chk({tag, "_valid"}, bif.bus_valid, 0);
    endtask

    initial begin
        logic [7:0] rr_ord [4];
        bif.ch_data = '0; bif.ch_data_en = '0; bif.bus_ready = 1'b0; bif.drop_clr = '0;
        m_valid = 1'b0; m_data = '0; m_id = 0; m_last = N - 1; m_drop = '0;

        // Reset while every input toggles
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < N; k++) bif.ch_data[k*32 +: 32] = $urandom;
            bif.ch_data_en = 4'($urandom);
            bif.bus_ready  = 1'($urandom);
            bif.drop_clr   = 4'($urandom);
            tick();
        end
        chk("rst_valid", bif.bus_valid, 0);
        chk("rst_data", bif.bus_data, 0);
        chk("rst_id", bif.bus_id, 0);
        chk("rst_drop", bif.drop_flags, 0);
        chk("rst_busy", bif.busy, 0);

        // Minimum latency
        rst = 1'b1; idle(); bif.bus_ready = 1'b1;
        put(2, 32'h0000_1234);
        tick();
        idle();
        expect_word("lat", 2, 32'h0000_1234);
        expect_idle("lat_done");
        chk("lat_busy", bif.busy, 0);

        // Round robin from last_grant=3, then from last_grant=1
        rst = 1'b0; tick(); rst = 1'b1;
        for (int k = 0; k < N; k++) put(k, 32'hA0 + k);
        tick();
        idle();
        for (int k = 0; k < N; k++) expect_word("rr0", k, 32'hA0 + k);
        expect_idle("rr0_done");
        put(0, 32'h50); put(1, 32'h51);
        tick();
        idle();
        expect_word("rr_pre0", 0, 32'h50);
        expect_word("rr_pre1", 1, 32'h51);
        expect_idle("rr_pre_done");
        for (int k = 0; k < N; k++) put(k, 32'hB0 + k);
        tick();
        idle();
        rr_ord = '{8'd2, 8'd3, 8'd0, 8'd1};
        for (int i = 0; i < N; i++) expect_word("rr1", rr_ord[i], 32'hB0 + rr_ord[i]);
        expect_idle("rr1_done");

        // Backpressure: word stays put and the pending ch0 word is not popped
        bif.bus_ready = 1'b0;
        put(3, 32'h33);
        tick();
        idle();
        put(0, 32'h44);
        for (int c = 0; c < 5; c++) begin
            expect_word("bp_hold", 3, 32'h33);
            idle();
        end
        bif.bus_ready = 1'b1;
        expect_word("bp_next", 0, 32'h44);
        expect_idle("bp_done");

        // Overflow on ch1 while the output register holds a ch1 word
        bif.bus_ready = 1'b0;
        put(1, 32'h10);
        tick();
        idle();
        expect_word("ov_hold", 1, 32'h10);
        put(1, 32'h11); tick();
        put(1, 32'h12); tick();
        put(1, 32'h13); tick();
        idle();
        chk("ov_flag", bif.drop_flags[1], 1);
        bif.bus_ready = 1'b1;
        expect_word("ov_a", 1, 32'h11);
        expect_word("ov_b", 1, 32'h12);
        expect_idle("ov_done");

        // Drop clear: set wins over a same-cycle clear, a lone clear works
        bif.bus_ready = 1'b0;
        bif.drop_clr = 4'b0010; tick(); idle();
        chk("clr_first", bif.drop_flags[1], 0);
        put(1, 32'h20); tick();
        put(1, 32'h21); tick();
        put(1, 32'h22); tick();
        put(1, 32'h23); bif.drop_clr = 4'b0010; tick(); idle();
        chk("clr_setwins", bif.drop_flags[1], 1);
        bif.drop_clr = 4'b0010; tick(); idle();
        chk("clr_alone", bif.drop_flags[1], 0);
        bif.bus_ready = 1'b1;
        expect_word("clr_a", 1, 32'h21);
        expect_word("clr_b", 1, 32'h22);
        expect_idle("clr_done");

        // Full ch0 FIFO popped while a third word is pushed
        bif.bus_ready = 1'b0;
        put(0, 32'h30); tick();
        put(0, 32'h31); tick();
        put(0, 32'h32); tick();
        bif.bus_ready = 1'b1;
        put(0, 32'h33);
        expect_word("fp_a", 0, 32'h31);
        idle();
        chk("fp_nodrop", bif.drop_flags[0], 0);
        expect_word("fp_b", 0, 32'h32);
        expect_word("fp_c", 0, 32'h33);
        expect_idle("fp_done");

        // Randomized traffic with occasional clears and resets
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) bif.ch_data[k*32 +: 32] = $urandom;
            bif.ch_data_en = 4'($urandom & $urandom);
            bif.bus_ready  = ($urandom_range(0, 3) != 0);
            bif.drop_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
            rst            = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
